// File: rtl/snes_bus_sync_pkg.sv
// Shared constants and types for the SNES bus front-end.
package snes_bus_pkg;

    // SNES strobes are active low.
    localparam logic STROBE_ACTIVE = 1'b0;

    localparam int ADDR_W = 24;
    localparam int PA_W   = 8;
    localparam int DATA_W = 8;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILTER_LEN_DEF  = 3;

    // One sample of the non-strobe bus lines, kept together so they move as a unit.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PA_W-1:0]   pa;
        logic [DATA_W-1:0] data;
        logic              cs;
    } bus_sample_t;

    function automatic logic is_active(input logic level);
        return level == STROBE_ACTIVE;
    endfunction

endpackage

// File: rtl/snes_bus_sync_if.sv
// SNES bus bundle: raw asynchronous inputs and the synchronised, latched outputs.
interface snes_bus_sync_if;
    import snes_bus_pkg::*;

    logic [ADDR_W-1:0] SNES_ADDR_IN;
    logic [PA_W-1:0]   SNES_PA_IN;
    logic [DATA_W-1:0] SNES_DATA_IN;
    logic              SNES_READ_IN;
    logic              SNES_WRITE_IN;
    logic              SNES_PARD_IN;
    logic              SNES_PAWR_IN;
    logic              SNES_CS_IN;

    logic [ADDR_W-1:0] SNES_ADDR;
    logic [PA_W-1:0]   SNES_PA;
    logic              SNES_CS;
    logic [DATA_W-1:0] SNES_WR_DATA;
    logic              rd_start;
    logic              rd_end;
    logic              wr_start;
    logic              wr_end;
    logic              pard_start;
    logic              pawr_end;
    logic              cycle_active;
    logic              bus_err;

    // The SNES side drives the raw lines and observes the results.
    modport master (
        output SNES_ADDR_IN, SNES_PA_IN, SNES_DATA_IN, SNES_READ_IN, SNES_WRITE_IN,
               SNES_PARD_IN, SNES_PAWR_IN, SNES_CS_IN,
        input  SNES_ADDR, SNES_PA, SNES_CS, SNES_WR_DATA, rd_start, rd_end, wr_start,
               wr_end, pard_start, pawr_end, cycle_active, bus_err
    );

    // The synchroniser consumes the raw lines and produces the clean view.
    modport slave (
        input  SNES_ADDR_IN, SNES_PA_IN, SNES_DATA_IN, SNES_READ_IN, SNES_WRITE_IN,
               SNES_PARD_IN, SNES_PAWR_IN, SNES_CS_IN,
        output SNES_ADDR, SNES_PA, SNES_CS, SNES_WR_DATA, rd_start, rd_end, wr_start,
               wr_end, pard_start, pawr_end, cycle_active, bus_err
    );

endinterface

// File: rtl/snes_bus_sync_strobe_filter.sv
// Synchronises one raw strobe and deglitches it: the filtered level only moves
// once FILTER_LEN consecutive synced samples agree on the opposite level.
module strobe_filter
    import snes_bus_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic strobe,
    output logic level,
    output logic fall,
    output logic rise
);

    // The synchroniser and the filter history share one shift chain: the first
    // SYNC_STAGES bits are the metastability flops, the oldest FILTER_LEN bits
    // (ending at the synchroniser output) form the comparison window.
    localparam int CHAIN_LEN = SYNC_STAGES + FILTER_LEN - 1;

    logic [CHAIN_LEN-1:0]  chain;
    logic [FILTER_LEN-1:0] window;
    logic                  to_active;
    logic                  to_idle;

    assign window    = chain[CHAIN_LEN-1 -: FILTER_LEN];
    assign to_active = !is_active(level) && (window == {FILTER_LEN{STROBE_ACTIVE}});
    assign to_idle   =  is_active(level) && (window == {FILTER_LEN{~STROBE_ACTIVE}});

    // Shift in the raw strobe, update the filtered level and emit edge pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            chain <= {CHAIN_LEN{~STROBE_ACTIVE}};
            level <= ~STROBE_ACTIVE;
            fall  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            chain <= {chain[CHAIN_LEN-2:0], strobe};
            fall  <= to_active;
            rise  <= to_idle;
            if (to_active) begin
                level <= STROBE_ACTIVE;
            end else if (to_idle) begin
                level <= ~STROBE_ACTIVE;
            end
        end
    end

endmodule

// File: rtl/snes_bus_sync.sv
// SNES bus front-end: synchronises and deglitches the bus strobes, produces
// per-cycle start/end pulses and latches address, PA and write data.
module snes_bus_sync
    import snes_bus_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    snes_bus_sync_if.slave  bus
);

    // Bus lines are delayed by the synchroniser plus FILTER_LEN alignment stages.
    // The tail then presents the sample taken when the strobe window began: on a
    // start pulse that is the first low sample, and on the edge where the level
    // rises it is the last low sample, which is what the write data must hold.
    localparam int PIPE_LEN = SYNC_STAGES + FILTER_LEN;

    bus_sample_t raw;
    bus_sample_t pipe [PIPE_LEN];
    bus_sample_t aligned;

    logic filt_rd, rd_fall, rd_rise;
    logic filt_wr, wr_fall, wr_rise;
    logic filt_pard, pard_fall, pard_rise;
    logic filt_pawr, pawr_fall, pawr_rise;

    logic rw_overlap;
    logic wr_conflict;
    logic wr_start_ok;
    logic unused_strobe;

    assign raw     = {bus.SNES_ADDR_IN, bus.SNES_PA_IN, bus.SNES_DATA_IN, bus.SNES_CS_IN};
    assign aligned = pipe[PIPE_LEN-1];

    strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_rd (
        .CLK(CLK), .RST(RST), .strobe(bus.SNES_READ_IN),
        .level(filt_rd), .fall(rd_fall), .rise(rd_rise)
    );

    strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_wr (
        .CLK(CLK), .RST(RST), .strobe(bus.SNES_WRITE_IN),
        .level(filt_wr), .fall(wr_fall), .rise(wr_rise)
    );

    strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_pard (
        .CLK(CLK), .RST(RST), .strobe(bus.SNES_PARD_IN),
        .level(filt_pard), .fall(pard_fall), .rise(pard_rise)
    );

    strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_pawr (
        .CLK(CLK), .RST(RST), .strobe(bus.SNES_PAWR_IN),
        .level(filt_pawr), .fall(pawr_fall), .rise(pawr_rise)
    );

    // The end of a B-bus read and the filtered PARD level carry no downstream meaning.
    assign unused_strobe = &{1'b0, pard_rise, filt_pard};

    assign rw_overlap = is_active(filt_rd) && is_active(filt_wr);

    // A write that starts while a read is already (or simultaneously) low is
    // treated as a bus fault: its pulses are dropped, the read carries on.
    assign wr_start_ok = wr_fall && !is_active(filt_rd);

    assign bus.rd_start   = rd_fall;
    assign bus.rd_end     = rd_rise;
    assign bus.wr_start   = wr_start_ok;
    assign bus.wr_end     = wr_rise && !wr_conflict;
    assign bus.pard_start = pard_fall;
    assign bus.pawr_end   = pawr_rise;

    // Synchroniser and alignment pipeline for the multi-bit bus lines.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < PIPE_LEN; i++) begin
                pipe[i] <= '1;
            end
        end else begin
            pipe[0] <= raw;
            for (int i = 1; i < PIPE_LEN; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Latch per-cycle bus values and track activity and the read/write fault.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.SNES_ADDR    <= '0;
            bus.SNES_CS      <= 1'b1;
            bus.SNES_PA      <= '0;
            bus.SNES_WR_DATA <= '0;
            bus.cycle_active <= 1'b0;
            bus.bus_err      <= 1'b0;
            wr_conflict      <= 1'b0;
        end else begin
            if (rd_fall || wr_start_ok) begin
                bus.SNES_ADDR <= aligned.addr;
                bus.SNES_CS   <= aligned.cs;
            end
            if (pard_fall || pawr_fall) begin
                bus.SNES_PA <= aligned.pa;
            end
            if (is_active(filt_wr) || is_active(filt_pawr)) begin
                bus.SNES_WR_DATA <= aligned.data;
            end
            bus.cycle_active <= is_active(filt_rd) || is_active(filt_wr);
            if (rw_overlap) begin
                bus.bus_err <= 1'b1;
            end
            if (wr_fall) begin
                wr_conflict <= is_active(filt_rd);
            end else if (rw_overlap) begin
                wr_conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snes_bus_sync.sv
// Directed bench for snes_bus_sync with the default SYNC_STAGES=2, FILTER_LEN=3.
// Inputs change and outputs are sampled on the falling clock edge; iteration i
// of a vector drives the value seen by rising edge i+1, so a pulse expected
// "after the 5th edge" shows up at sample index 4.
module tb_snes_bus_sync;
    import snes_bus_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    snes_bus_sync_if bus();

    snes_bus_sync #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    localparam int NCYC = 20;

    typedef struct {
        string       name;
        int          rd_len, wr_len, pard_len, pawr_len;
        logic [23:0] addr;
        logic [7:0]  pa;
        logic        cs;
        logic [7:0]  data_a, data_b, data_c;
        int          sw, de;
        int          e_rd_s, e_rd_e, e_wr_s, e_wr_e, e_pard_s, e_pawr_e;
        logic [23:0] e_addr;
        logic [7:0]  e_pa;
        logic        e_cs;
        logic [7:0]  e_data;
        logic        e_err;
        logic        e_cyc;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.SNES_READ_IN  = 1'b1;
        bus.SNES_WRITE_IN = 1'b1;
        bus.SNES_PARD_IN  = 1'b1;
        bus.SNES_PAWR_IN  = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " rd_start"},     32'(bus.rd_start),     32'd0);
        chk({tag, " rd_end"},       32'(bus.rd_end),       32'd0);
        chk({tag, " wr_start"},     32'(bus.wr_start),     32'd0);
        chk({tag, " wr_end"},       32'(bus.wr_end),       32'd0);
        chk({tag, " pard_start"},   32'(bus.pard_start),   32'd0);
        chk({tag, " pawr_end"},     32'(bus.pawr_end),     32'd0);
        chk({tag, " addr"},         32'(bus.SNES_ADDR),    32'd0);
        chk({tag, " pa"},           32'(bus.SNES_PA),      32'd0);
        chk({tag, " cs"},           32'(bus.SNES_CS),      32'd1);
        chk({tag, " wr_data"},      32'(bus.SNES_WR_DATA), 32'd0);
        chk({tag, " cycle_active"}, 32'(bus.cycle_active), 32'd0);
        chk({tag, " bus_err"},      32'(bus.bus_err),      32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int rd_s = -1, rd_e = -1, wr_s = -1, wr_e = -1, pard_s = -1, pawr_e = -1;
        int n_rd_s = 0, n_rd_e = 0, n_wr_s = 0, n_wr_e = 0, n_pard_s = 0, n_pawr_e = 0;
        logic       cyc_seen = 1'b0;
        logic [7:0] end_data = 8'h00;
        bus.SNES_ADDR_IN = v.addr;
        bus.SNES_PA_IN   = v.pa;
        bus.SNES_CS_IN   = v.cs;
        for (int i = 0; i < NCYC; i++) begin
            bus.SNES_READ_IN  = (i < v.rd_len)   ? 1'b0 : 1'b1;
            bus.SNES_WRITE_IN = (i < v.wr_len)   ? 1'b0 : 1'b1;
            bus.SNES_PARD_IN  = (i < v.pard_len) ? 1'b0 : 1'b1;
            bus.SNES_PAWR_IN  = (i < v.pawr_len) ? 1'b0 : 1'b1;
            bus.SNES_DATA_IN  = (i < v.sw) ? v.data_a : ((i < v.de) ? v.data_b : v.data_c);
            step();
            if (bus.rd_start)   begin n_rd_s++;   if (rd_s < 0)   rd_s = i;   end
            if (bus.rd_end)     begin n_rd_e++;   if (rd_e < 0)   rd_e = i;   end
            if (bus.wr_start)   begin n_wr_s++;   if (wr_s < 0)   wr_s = i;   end
            if (bus.wr_end)     begin n_wr_e++;   if (wr_e < 0)   wr_e = i;   end
            if (bus.pard_start) begin n_pard_s++; if (pard_s < 0) pard_s = i; end
            if (bus.pawr_end)   begin n_pawr_e++; if (pawr_e < 0) pawr_e = i; end
            if ((bus.wr_end || bus.pawr_end) && (wr_e == i || pawr_e == i)) end_data = bus.SNES_WR_DATA;
            if (bus.cycle_active) cyc_seen = 1'b1;
        end
        chk({v.name, " rd_start at"},   32'(rd_s),   32'(v.e_rd_s));
        chk({v.name, " rd_start n"},    32'(n_rd_s), 32'(v.e_rd_s >= 0));
        chk({v.name, " rd_end at"},     32'(rd_e),   32'(v.e_rd_e));
        chk({v.name, " rd_end n"},      32'(n_rd_e), 32'(v.e_rd_e >= 0));
        chk({v.name, " wr_start at"},   32'(wr_s),   32'(v.e_wr_s));
        chk({v.name, " wr_start n"},    32'(n_wr_s), 32'(v.e_wr_s >= 0));
        chk({v.name, " wr_end at"},     32'(wr_e),   32'(v.e_wr_e));
        chk({v.name, " wr_end n"},      32'(n_wr_e), 32'(v.e_wr_e >= 0));
        chk({v.name, " pard_start at"}, 32'(pard_s), 32'(v.e_pard_s));
        chk({v.name, " pard_start n"},  32'(n_pard_s), 32'(v.e_pard_s >= 0));
        chk({v.name, " pawr_end at"},   32'(pawr_e), 32'(v.e_pawr_e));
        chk({v.name, " pawr_end n"},    32'(n_pawr_e), 32'(v.e_pawr_e >= 0));
        if (v.e_wr_e >= 0 || v.e_pawr_e >= 0)
            chk({v.name, " wr_data at end pulse"}, 32'(end_data), 32'(v.e_data));
        chk({v.name, " addr"},         32'(bus.SNES_ADDR),    32'(v.e_addr));
        chk({v.name, " pa"},           32'(bus.SNES_PA),      32'(v.e_pa));
        chk({v.name, " cs"},           32'(bus.SNES_CS),      32'(v.e_cs));
        chk({v.name, " wr_data"},      32'(bus.SNES_WR_DATA), 32'(v.e_data));
        chk({v.name, " bus_err"},      32'(bus.bus_err),      32'(v.e_err));
        chk({v.name, " cycle_active"}, 32'(cyc_seen),         32'(v.e_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ws, we_n, ws2, we2, we2_n;

        //         name       rd wr pard pawr addr        pa     cs    a      b      c      sw de  rd_s rd_e wr_s wr_e pard_s pawr_e e_addr      e_pa   e_cs  e_data e_err e_cyc
        vecs[0] = '{"read",    8, 0, 0, 0, 24'h00FF80, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 0, 0,  4, 12, -1, -1, -1, -1, 24'h00FF80, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[1] = '{"write",   0, 6, 0, 0, 24'h7E2000, 8'h00, 1'b1, 8'h3C, 8'hA5, 8'h11, 3, 6, -1, -1,  4, 10, -1, -1, 24'h7E2000, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1};
        vecs[2] = '{"glitch",  2, 0, 0, 0, 24'h123456, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 0, 0, -1, -1, -1, -1, -1, -1, 24'h7E2000, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[3] = '{"pawr",    0, 0, 0, 5, 24'h654321, 8'h80, 1'b1, 8'h77, 8'h77, 8'h00, 0, 5, -1, -1, -1, -1, -1,  9, 24'h7E2000, 8'h80, 1'b1, 8'h77, 1'b0, 1'b0};
        vecs[4] = '{"pard_rd", 6, 0, 6, 0, 24'h002100, 8'h3F, 1'b1, 8'h00, 8'h00, 8'h00, 0, 0,  4, 10, -1, -1,  4, -1, 24'h002100, 8'h3F, 1'b1, 8'h77, 1'b0, 1'b1};
        vecs[5] = '{"rd_wr",   6, 6, 0, 0, 24'h008000, 8'h00, 1'b0, 8'h5A, 8'h5A, 8'h00, 0, 6,  4, 10, -1, -1, -1, -1, 24'h008000, 8'h3F, 1'b0, 8'h5A, 1'b1, 1'b1};

        idle_inputs();
        bus.SNES_ADDR_IN = 24'hABCDEF;
        bus.SNES_PA_IN   = 8'hEE;
        bus.SNES_DATA_IN = 8'hDD;
        bus.SNES_CS_IN   = 1'b0;
        RST = 1'b1;
        repeat (3) step();
        check_reset_state("reset");
        RST = 1'b0;
        repeat (2) step();

        for (int n = 0; n < 6; n++) begin
            run_vec(vecs[n]);
        end

        // bus_err stays set through idle time and only RST clears it
        idle_inputs();
        repeat (5) step();
        chk("bus_err sticky", 32'(bus.bus_err), 32'd1);
        RST = 1'b1;
        repeat (2) step();
        check_reset_state("err reset");
        RST = 1'b0;
        repeat (2) step();

        // reset in the middle of a write, strobe still low when reset releases
        bus.SNES_ADDR_IN  = 24'h445566;
        bus.SNES_CS_IN    = 1'b0;
        bus.SNES_DATA_IN  = 8'h99;
        bus.SNES_WRITE_IN = 1'b0;
        ws = -1;
        we_n = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus.wr_start && ws < 0) ws = i;
            if (bus.wr_end) we_n++;
        end
        chk("mid wr_start at", 32'(ws), 32'd4);
        chk("mid addr before reset", 32'(bus.SNES_ADDR), 32'h445566);
        chk("mid cycle_active before reset", 32'(bus.cycle_active), 32'd1);
        RST = 1'b1;
        step();
        check_reset_state("mid reset");
        if (bus.wr_end) we_n++;
        step();
        if (bus.wr_end) we_n++;
        RST = 1'b0;
        ws2 = -1;
        we2 = -1;
        we2_n = 0;
        for (int i = 0; i < 14; i++) begin
            bus.SNES_WRITE_IN = (i < 6) ? 1'b0 : 1'b1;
            step();
            if (bus.wr_start && ws2 < 0) ws2 = i;
            if (bus.wr_end) begin
                we2_n++;
                if (we2 < 0) we2 = i;
            end
        end
        chk("mid no wr_end around reset", 32'(we_n), 32'd0);
        chk("post reset wr_start at", 32'(ws2), 32'd4);
        chk("post reset wr_end at", 32'(we2), 32'd10);
        chk("post reset wr_end n", 32'(we2_n), 32'd1);
        chk("post reset addr", 32'(bus.SNES_ADDR), 32'h445566);
        chk("post reset cs", 32'(bus.SNES_CS), 32'd0);
        chk("post reset wr_data", 32'(bus.SNES_WR_DATA), 32'h99);
        chk("post reset bus_err", 32'(bus.bus_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snes_bus_sync.md
Name: snes_bus_sync

Overview:
Front-end stage that feeds the Cx4 address decoder and MMIO logic. It synchronises the asynchronous SNES bus (address, PA, data, /RD, /WR, /PARD, /PAWR, /ROMSEL) into the CLK domain and deglitches the strobes. It emits one-cycle start/end pulses per bus cycle and latches address and write data, so downstream logic sees stable per-cycle values.

Parameters:
SYNC_STAGES, 2, flip-flop depth of every input synchroniser (min 2)
FILTER_LEN, 3, consecutive identical synced samples required before a strobe's filtered level changes (min 1)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
SNES_ADDR_IN  input  24  raw A-bus address
SNES_PA_IN  input  8  raw B-bus address
SNES_DATA_IN  input  8  raw data bus
SNES_READ_IN  input  1  raw /RD, active low
SNES_WRITE_IN  input  1  raw /WR, active low
SNES_PARD_IN  input  1  raw /PARD, active low
SNES_PAWR_IN  input  1  raw /PAWR, active low
SNES_CS_IN  input  1  raw /ROMSEL, active low
SNES_ADDR  output  24  address latched at rd/wr start
SNES_PA  output  8  PA latched at pard/pawr start
SNES_CS  output  1  /ROMSEL latched with SNES_ADDR
SNES_WR_DATA  output  8  write data, valid with wr_end/pawr_end
rd_start, rd_end, wr_start, wr_end  output  1 each  A-bus cycle pulses
pard_start, pawr_end  output  1 each  B-bus cycle pulses
cycle_active  output  1  filtered /RD or /WR currently low
bus_err  output  1  sticky: /RD and /WR filtered-low simultaneously

Behaviour:
- Synchronisers: all inputs pass through SYNC_STAGES flops. Multi-bit buses are synced per bit and consumed only when the strobe is stable.
- Filter per strobe: filtered level starts deasserted (1). It flips when the last FILTER_LEN synced samples all equal the opposite level.
  - Falling flip produces *_start.
  - Rising flip produces *_end.
  - Each pulse is high exactly 1 cycle.
- Latency: the pulse is high in the cycle after edge k+SYNC_STAGES+FILTER_LEN-1, where edge k is the first edge that samples the new raw level. With defaults, the pulse is high after the 5th edge, counting edge k as the 1st.
- Glitches shorter than FILTER_LEN synced samples produce no pulse and no latch.
- Address latch:
  - On the rd_start or wr_start edge, SNES_ADDR and SNES_CS load the synced values; they hold until the next start.
  - On pard_start or a pawr start, SNES_PA loads the synced value.
  - The pawr start is internal only; no port.
- Write data: SNES_WR_DATA reloads from synced data every cycle while filtered /WR or /PAWR is low. It freezes on the cycle *_end fires, so the value equals the last synced sample before the strobe rose. It holds until the next write.
- cycle_active = ~filt_rd | ~filt_wr, registered.
- Simultaneous /RD and /WR filtered-low:
  - Read proceeds normally.
  - wr_start and wr_end are suppressed for that write cycle.
  - The data register still loads.
  - bus_err sets and stays set until RST.
- /RD and /PARD low together (normal B-bus read): both rd_start and pard_start fire. No error.
- Back-to-back cycles: an end and the next start may not share a cycle (filter guarantees ≥ FILTER_LEN cycles between them). No minimum idle is otherwise required.
- Reset values, applied synchronously when RST=1:
  - All pulses 0; SNES_ADDR 0; SNES_PA 0; SNES_CS 1; SNES_WR_DATA 0; cycle_active 0; bus_err 0.
  - Synchroniser and filter history all 1.
- Reset mid-cycle: the in-flight cycle is abandoned; no end pulse is emitted for it.
- Strobe already low at reset release: a start pulse is emitted after the normal latency.

Decomposition:
- Package snes_bus_pkg:
  - STROBE_ACTIVE = 1'b0
  - A-bus width 24, PA width 8, data width 8
  - defaults for SYNC_STAGES and FILTER_LEN
- Sub-module strobe_filter (params SYNC_STAGES, FILTER_LEN):
  - inputs CLK, RST, raw strobe; outputs filtered level, fall pulse, rise pulse.
  - Instantiated 4x (/RD, /WR, /PARD, /PAWR).
- Bus synchronisers stay inline in the top module.

Test Plan:
1. Defaults. ADDR_IN=0x00FF80; drop /RD for 8 cycles, then raise. Required: rd_start after the 5th edge, SNES_ADDR=0x00FF80, rd_end 5 edges after the rise, no wr pulses.
2. /WR low 6 cycles with DATA_IN=0x3C, changing to 0xA5 for the final 3 cycles before the rise. Required: wr_end fires and SNES_WR_DATA=0xA5 from that cycle on.
3. /RD glitch low for 2 cycles (< FILTER_LEN). Required: no rd_start, SNES_ADDR unchanged, cycle_active stays 0.
4. /RD and /WR both low 6 cycles. Required: rd_start/rd_end fire, wr_start/wr_end never fire, bus_err=1 until RST.
5. PA_IN=0x3F with /PARD and /RD low together. Required: pard_start and rd_start in the same cycle, SNES_PA=0x3F, bus_err=0.
6. RST asserted 3 cycles after wr_start while /WR is held low. Required: all outputs return to reset values, no wr_end; after RST release with /WR still low, wr_start fires 5 edges later.
